// File: rtl/byte_striping_pkg.sv
// Shared lane-striping definitions: K-code symbols, framing state encoding, symbol classifiers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package byte_striping_pkg;

    // K-code control symbols (valid only when the K flag is set)
    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] END = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;
    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [7:0] IDL = 8'h7C;

    // Framing state encoding, shared with the transmit side
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PKT  = 1'b1;

    function automatic logic is_start(input logic [7:0] sym);
        return (sym == STP) || (sym == SDP);
    endfunction

    function automatic logic is_end(input logic [7:0] sym);
        return (sym == END) || (sym == EDB);
    endfunction

    function automatic logic is_known_k(input logic [7:0] sym);
        return is_start(sym) || is_end(sym) ||
               (sym == COM) || (sym == SKP) || (sym == IDL);
    endfunction

endpackage

// File: rtl/unstripe_framer.sv
// Packet framing tracker on the merged byte stream; optional sticky checker (macro FRAME_CHECK_EN).
// Latency: state/error register on the same edge the byte is loaded into D.
// Backpressure: none; observes every valid byte presented.
module unstripe_framer
    import byte_striping_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic            CLK,
    input  logic            RESET_L,
    input  logic [BITS-1:0] sym_dat,
    input  logic            sym_k,
    input  logic            sym_vld,
    output logic            IN_PKT,
    output logic            ERR
);

    logic [0:0] state;
    logic [0:0] state_nxt;

    // Next framing state from the byte about to be presented on D
    always_comb begin
        state_nxt = state;
        if (sym_vld && sym_k) begin
            if (state == IDLE && is_start(sym_dat))
                state_nxt = PKT;
            else if (state == PKT && is_end(sym_dat))
                state_nxt = IDLE;
        end
    end

    // Framing state register
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign IN_PKT = (state == PKT);

`ifdef FRAME_CHECK_EN
    logic err_q;
    logic err_hit;

    // Classify the incoming byte against the current framing state
    always_comb begin
        err_hit = 1'b0;
        if (sym_vld) begin
            if (sym_k && state == PKT && is_start(sym_dat))
                err_hit = 1'b1;
            if (sym_k && state == IDLE && is_end(sym_dat))
                err_hit = 1'b1;
            if (!sym_k && state == IDLE)
                err_hit = 1'b1;
            if (sym_k && !is_known_k(sym_dat))
                err_hit = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L)
            err_q <= 1'b0;
        else
            err_q <= err_q | err_hit;
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: rtl/byte_unstriping.sv
// Re-serialises a LANES-wide lane group into one byte/clk (lane 0 first) and tracks framing; macro FRAME_CHECK_EN enables ERR.
// Latency: LANE0 on D one edge after accept, LANE(LANES-1) LANES edges after; back-to-back groups gapless.
// Backpressure: READY_IN high only when no group is being emitted; upstream holds VALID_IN/lanes otherwise.
module byte_unstriping
    import byte_striping_pkg::*;
#(
    parameter int LANES = 4,
    parameter int BITS  = 8
) (
    input  logic            CLK,
    input  logic            RESET_L,
    input  logic            VALID_IN,
    output logic            READY_IN,
    input  logic [BITS-1:0] LANE0,
    input  logic [BITS-1:0] LANE1,
    input  logic [BITS-1:0] LANE2,
    input  logic [BITS-1:0] LANE3,
    input  logic            DK_0,
    input  logic            DK_1,
    input  logic            DK_2,
    input  logic            DK_3,
    output logic [BITS-1:0] D,
    output logic            DK,
    output logic            VALID_OUT,
    output logic            IN_PKT,
    output logic            ERR
);

    localparam int CNT_W = $clog2(LANES);
    localparam int BUF_W = (LANES - 1) * BITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANES - 1);

    logic [CNT_W-1:0] cnt;
    // Lanes 1..LANES-1 held here; lane 1 sits in the low slot and shifts out first
    logic [BUF_W-1:0] buf_dat;
    logic [LANES-2:0] buf_k;

    logic             accept;
    logic [BITS-1:0]  d_nxt;
    logic             dk_nxt;
    logic             vld_nxt;

    assign READY_IN = (cnt == '0);
    assign accept   = VALID_IN & READY_IN;

    // Select the byte to present on D next edge: buffered lane mid-group, else LANE0 on accept
    always_comb begin
        d_nxt   = '0;
        dk_nxt  = 1'b0;
        vld_nxt = 1'b0;
        if (cnt != '0) begin
            d_nxt   = buf_dat[BITS-1:0];
            dk_nxt  = buf_k[0];
            vld_nxt = 1'b1;
        end else if (VALID_IN) begin
            d_nxt   = LANE0;
            dk_nxt  = DK_0;
            vld_nxt = 1'b1;
        end
    end

    // Byte index, output register and holding buffer
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            cnt       <= '0;
            D         <= '0;
            DK        <= 1'b0;
            VALID_OUT <= 1'b0;
            buf_dat   <= '0;
            buf_k     <= '0;
        end else begin
            D         <= d_nxt;
            DK        <= dk_nxt;
            VALID_OUT <= vld_nxt;
            if (accept) begin
                cnt     <= CNT_W'(1);
                buf_dat <= {LANE3, LANE2, LANE1};
                buf_k   <= {DK_3, DK_2, DK_1};
            end else if (cnt != '0) begin
                cnt     <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
                buf_dat <= {BITS'(0), buf_dat[BUF_W-1:BITS]};
                buf_k   <= {1'b0, buf_k[LANES-2:1]};
            end
        end
    end

    unstripe_framer #(
        .BITS(BITS)
    ) u_framer (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .sym_dat (d_nxt),
        .sym_k   (dk_nxt),
        .sym_vld (vld_nxt),
        .IN_PKT  (IN_PKT),
        .ERR     (ERR)
    );

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping: scoreboard of expected bytes, negedge monitor compares D/DK/IN_PKT/ERR.
// Latency: n/a.
// Backpressure: driver holds VALID_IN and lanes until READY_IN.
module tb_byte_unstriping;

    logic       CLK = 1'b0;
    logic       RESET_L = 1'b0;
    logic       VALID_IN = 1'b0;
    logic       READY_IN;
    logic [7:0] LANE0 = '0, LANE1 = '0, LANE2 = '0, LANE3 = '0;
    logic       DK_0 = 1'b0, DK_1 = 1'b0, DK_2 = 1'b0, DK_3 = 1'b0;
    logic [7:0] D;
    logic       DK, VALID_OUT, IN_PKT, ERR;

    typedef struct packed {
        logic [7:0] d;
        logic       dk;
        logic       in_pkt;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   run_len = 0;
    int   max_run = 0;

    byte_unstriping #(.LANES(4), .BITS(8)) dut (
        .CLK(CLK), .RESET_L(RESET_L), .VALID_IN(VALID_IN), .READY_IN(READY_IN),
        .LANE0(LANE0), .LANE1(LANE1), .LANE2(LANE2), .LANE3(LANE3),
        .DK_0(DK_0), .DK_1(DK_1), .DK_2(DK_2), .DK_3(DK_3),
        .D(D), .DK(DK), .VALID_OUT(VALID_OUT), .IN_PKT(IN_PKT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pop one expected entry per valid output byte
    always @(negedge CLK) begin
        if (RESET_L) begin
            if (VALID_OUT) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {24'h0, D}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("d", {24'h0, D}, {24'h0, e.d});
                    chk("dk", {31'h0, DK}, {31'h0, e.dk});
                    chk("in_pkt", {31'h0, IN_PKT}, {31'h0, e.in_pkt});
                    chk("err", {31'h0, ERR}, {31'h0, e.err});
                end
            end else begin
                run_len = 0;
                chk("idle_d_dk", {23'h0, DK, D}, 32'h0);
            end
        end
    end

    // Drive one group, wait for READY_IN (bounded), queue its four expected bytes
    task automatic send_group(input logic [31:0] lanes, input logic [3:0] ks,
                              input logic [3:0] pkt, input logic [3:0] err,
                              output int waited);
        VALID_IN = 1'b1;
        {LANE3, LANE2, LANE1, LANE0} = lanes;
        {DK_3, DK_2, DK_1, DK_0} = ks;
        waited = 0;
        while (!READY_IN && waited < 20) begin
            @(posedge CLK); #1;
            waited++;
        end
        if (!READY_IN) chk("ready_timeout", 32'h0, 32'h1);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.d = lanes[i*8 +: 8];
            e.dk = ks[i];
            e.in_pkt = pkt[i];
`ifdef FRAME_CHECK_EN
            e.err = err[i];
`else
            e.err = 1'b0;
`endif
            exp_q.push_back(e);
        end
        @(posedge CLK); #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        repeat (2) @(posedge CLK);
        #1;
        chk(name, exp_q.size(), 0);
        chk({name, "_valid_low"}, {31'h0, VALID_OUT}, 32'h0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_d"}, {24'h0, D}, 32'h0);
        chk({name, "_dk"}, {31'h0, DK}, 32'h0);
        chk({name, "_valid"}, {31'h0, VALID_OUT}, 32'h0);
        chk({name, "_in_pkt"}, {31'h0, IN_PKT}, 32'h0);
        chk({name, "_err"}, {31'h0, ERR}, 32'h0);
        chk({name, "_ready"}, {31'h0, READY_IN}, 32'h1);
    endtask

    initial begin
        int w;
        // Reset state
        #12;
        chk_reset_outputs("reset");
        @(posedge CLK); #1;
        RESET_L = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("post_reset_valid", {31'h0, VALID_OUT}, 32'h0);
        chk("post_reset_ready", {31'h0, READY_IN}, 32'h1);

        // Single group: FB(K) 33 FF FD(K)
        max_run = 0;
        send_group(32'hFD_FF_33_FB, 4'b1001, 4'b0111, 4'b0000, w);
        VALID_IN = 1'b0;
        chk("single_wait", w, 0);
        wait_drain("single_drain");
        chk("single_run_len", max_run, 4);

        // Back-to-back groups with VALID_IN held
        max_run = 0;
        send_group(32'hFD_FF_33_FB, 4'b1001, 4'b0111, 4'b0000, w);
        chk("b2b_wait0", w, 0);
        send_group(32'hFE_41_55_5C, 4'b1001, 4'b0111, 4'b0000, w);
        chk("b2b_wait1", w, 3);
        VALID_IN = 1'b0;
        wait_drain("b2b_drain");
        chk("b2b_run_len", max_run, 8);

        // Continuous VALID_IN over three groups: each consumed exactly once
        max_run = 0;
        send_group(32'h03_02_01_FB, 4'b0001, 4'b1111, 4'b0000, w);
        send_group(32'h07_06_05_04, 4'b0000, 4'b1111, 4'b0000, w);
        chk("bp_wait", w, 3);
        send_group(32'hFD_0A_09_08, 4'b1000, 4'b0111, 4'b0000, w);
        chk("bp_wait2", w, 3);
        VALID_IN = 1'b0;
        wait_drain("bp_drain");
        chk("bp_run_len", max_run, 12);

        // Mid-group reset after LANE1 reaches D
        send_group(32'hFE_BB_AA_5C, 4'b1001, 4'b0111, 4'b0000, w);
        VALID_IN = 1'b0;
        @(posedge CLK);
        @(negedge CLK); #1;
        chk("mid_d_lane1", {24'h0, D}, 32'hAA);
        RESET_L = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        exp_q.delete();
        @(posedge CLK); #1;
        RESET_L = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("mid_post_valid", {31'h0, VALID_OUT}, 32'h0);
        send_group(32'hFD_FF_33_FB, 4'b1001, 4'b0111, 4'b0000, w);
        VALID_IN = 1'b0;
        wait_drain("mid_restart_drain");

        // Framing error: SDP inside a packet; ERR sticky until reset
        send_group(32'hFD_5C_33_FB, 4'b1101, 4'b0111, 4'b1100, w);
        VALID_IN = 1'b0;
        wait_drain("err_drain");
`ifdef FRAME_CHECK_EN
        chk("err_sticky", {31'h0, ERR}, 32'h1);
`else
        chk("err_tied_low", {31'h0, ERR}, 32'h0);
`endif
        RESET_L = 1'b0;
        #1;
        chk("err_after_reset", {31'h0, ERR}, 32'h0);
        @(posedge CLK); #1;
        RESET_L = 1'b1;
        repeat (2) @(posedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
